// File: rtl/qam16_ber_checker.sv
// qam16_ber_checker: 16-QAM slicer with PRBS-23 sync FSM and saturating bit/error counters.
// Optional feature macro QAM16_BER_ERR_INJECT_EN adds inject_err to flip b3 after slicing.
module qam16_ber_checker #(
    parameter int SLICE_THR   = 1296,
    parameter int VERIFY_SYMS = 8,
    parameter int LOSS_WIN    = 64,
    parameter int LOSS_THRESH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [11:0] sym_i,
    input  logic signed [11:0] sym_q,
    input  logic               sym_valid,
    input  logic               cnt_clr,
`ifdef QAM16_BER_ERR_INJECT_EN
    input  logic               inject_err,
`endif
    output logic [3:0]         bits_out,
    output logic               bits_valid,
    output logic               sym_err,
    output logic               locked,
    output logic [31:0]        bit_cnt,
    output logic [31:0]        err_cnt
);
    localparam int VW = $clog2(VERIFY_SYMS + 1);
    localparam int WW = $clog2(LOSS_WIN + 1);
    localparam int EW = $clog2(LOSS_THRESH + 4);
    localparam logic signed [11:0] THR = 12'(SLICE_THR);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state, state_n;
    logic [22:0]   s, s_n;
    logic [4:0]    fill, fill_n;
    logic [VW-1:0] vcnt, vcnt_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [EW-1:0] werr, werr_n, acc;
    logic [3:0]    rx;
    logic [2:0]    errs;
    logic [32:0]   bit_sum, err_sum;

    function automatic logic [1:0] slice(input logic signed [11:0] x);
        return x >= THR ? 2'b10 : !x[11] ? 2'b11 : x > -THR ? 2'b01 : 2'b00;
    endfunction

    // Slice the symbol, then run its four bits through the x^23+x^18+1 predictor, b3 first
    always_comb begin
        rx = {slice(sym_i), slice(sym_q)};
`ifdef QAM16_BER_ERR_INJECT_EN
        rx[3] = rx[3] ^ inject_err;
`endif
        s_n = s;
        errs = 3'd0;
        for (int k = 3; k >= 0; k--) begin
            errs = errs + {2'b0, s_n[22] ^ s_n[17] ^ rx[k]};
            s_n = {s_n[21:0], state == LOCKED ? s_n[22] ^ s_n[17] : rx[k]};
        end
        acc = werr + EW'(errs);
        bit_sum = {1'b0, bit_cnt} + 33'd4;
        err_sum = {1'b0, err_cnt} + {30'b0, errs};
    end

    // Sync FSM next-state: fill in SEARCH, clean-symbol run in VERIFY, windowed loss check in LOCKED
    always_comb begin
        state_n = state;
        fill_n = fill;
        vcnt_n = vcnt;
        wcnt_n = wcnt;
        werr_n = werr;
        case (state)
            SEARCH: begin
                fill_n = fill + 5'd4;
                if (fill_n >= 5'd23) begin
                    state_n = VERIFY;
                    vcnt_n = '0;
                end
            end
            VERIFY: begin
                if (errs != 3'd0) begin
                    state_n = SEARCH;
                    fill_n = '0;
                end else if (vcnt == VW'(VERIFY_SYMS - 1)) begin
                    state_n = LOCKED;
                    wcnt_n = '0;
                    werr_n = '0;
                end else begin
                    vcnt_n = vcnt + 1'b1;
                end
            end
            LOCKED: begin
                if (acc >= EW'(LOSS_THRESH)) begin
                    state_n = SEARCH;
                    fill_n = '0;
                    wcnt_n = '0;
                    werr_n = '0;
                end else if (wcnt == WW'(LOSS_WIN - 1)) begin
                    wcnt_n = '0;
                    werr_n = '0;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                    werr_n = acc;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    // State and output registers; only qualified symbols advance the checker
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
            s <= '0;
            fill <= '0;
            vcnt <= '0;
            wcnt <= '0;
            werr <= '0;
            bits_out <= '0;
            bits_valid <= 1'b0;
            sym_err <= 1'b0;
            locked <= 1'b0;
        end else begin
            bits_valid <= sym_valid;
            sym_err <= sym_valid && state == LOCKED && errs != 3'd0;
            if (sym_valid) begin
                bits_out <= rx;
                s <= s_n;
                state <= state_n;
                fill <= fill_n;
                vcnt <= vcnt_n;
                wcnt <= wcnt_n;
                werr <= werr_n;
                locked <= state_n == LOCKED;
            end
        end
    end

    // Saturating counters; a clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            bit_cnt <= '0;
            err_cnt <= '0;
        end else if (sym_valid && state == LOCKED) begin
            bit_cnt <= bit_sum[32] ? '1 : bit_sum[31:0];
            err_cnt <= err_sum[32] ? '1 : err_sum[31:0];
        end
    end
endmodule

// File: tb/tb_qam16_ber_checker.sv
// tb_qam16_ber_checker: directed PRBS-23 stimulus against a history-based reference model.
module tb_qam16_ber_checker;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [11:0] sym_i = '0;
    logic signed [11:0] sym_q = '0;
    logic               sym_valid = 1'b0;
    logic               cnt_clr = 1'b0;
    logic [3:0]         bits_out;
    logic               bits_valid, sym_err, locked;
    logic [31:0]        bit_cnt, err_cnt;
`ifdef QAM16_BER_ERR_INJECT_EN
    logic               inject_err = 1'b0;
`endif

    qam16_ber_checker dut (
        .clk(clk), .rst(rst), .sym_i(sym_i), .sym_q(sym_q),
        .sym_valid(sym_valid), .cnt_clr(cnt_clr),
`ifdef QAM16_BER_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .bits_out(bits_out), .bits_valid(bits_valid), .sym_err(sym_err),
        .locked(locked), .bit_cnt(bit_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // reference model: mode 0 search, 1 verify, 2 locked; refq holds the last 23 reference bits
    int     m_mode, m_fill, m_ver, m_win, m_werr;
    bit     refq[$];
    longint m_bit, m_err;
    logic [3:0]  n_bits, e_bits;
    logic        n_bv, e_bv, n_se, e_se, n_lk, e_lk;
    logic [31:0] n_bc, e_bc, n_ec, e_ec;

    logic [22:0] tx_s = 23'h7FFFFF;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [1:0] slice(int x);
        if (x >= 1296) return 2'b10;
        if (x >= 0) return 2'b11;
        if (x > -1296) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int level(bit [1:0] p);
        return p == 2'b10 ? 1943 : p == 2'b11 ? 648 : p == 2'b01 ? -648 : -1943;
    endfunction

    task automatic model(bit v, int i, int q, bit c, bit r);
        int errs;
        bit [3:0] nib;
        bit p;
        if (r) begin
            m_mode = 0; m_fill = 0; m_ver = 0; m_win = 0; m_werr = 0; m_bit = 0; m_err = 0;
            refq = {};
            repeat (23) refq.push_back(1'b0);
            n_bits = 0; n_bv = 0; n_se = 0; n_lk = 0; n_bc = 0; n_ec = 0;
            return;
        end
        n_bv = v;
        n_se = 1'b0;
        errs = 0;
        if (v) begin
            nib = {slice(i), slice(q)};
            n_bits = nib;
            for (int k = 3; k >= 0; k--) begin
                p = refq[0] ^ refq[5];
                if (p != nib[k]) errs++;
                refq.push_back(m_mode == 2 ? p : nib[k]);
                void'(refq.pop_front());
            end
            if (m_mode == 2) begin
                n_se = errs > 0;
                m_bit = (m_bit + 4 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bit + 4;
                m_err = (m_err + errs > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_err + errs;
                m_werr += errs;
                m_win++;
                if (m_werr >= 16) begin
                    m_mode = 0; m_fill = 0; m_win = 0; m_werr = 0;
                end else if (m_win == 64) begin
                    m_win = 0; m_werr = 0;
                end
            end else if (m_mode == 1) begin
                if (errs > 0) begin
                    m_mode = 0; m_fill = 0;
                end else if (++m_ver == 8) begin
                    m_mode = 2; m_win = 0; m_werr = 0;
                end
            end else begin
                m_fill += 4;
                if (m_fill >= 23) begin
                    m_mode = 1; m_ver = 0;
                end
            end
        end
        if (c) begin
            m_bit = 0; m_err = 0;
        end
        n_lk = m_mode == 2;
        n_bc = 32'(m_bit);
        n_ec = 32'(m_err);
    endtask

    // called at posedge+1: apply inputs for the next edge and advance the model
    task automatic drive(bit v, int i, int q, bit c, bit r);
        sym_valid = v; sym_i = 12'(i); sym_q = 12'(q); cnt_clr = c; rst = r;
        model(v, i, q, c, r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    task automatic send_tx(bit inv, bit qflip, bit c, bit r);
        bit [3:0] nib;
        bit b;
        int q;
        for (int k = 3; k >= 0; k--) begin
            b = tx_s[22] ^ tx_s[17];
            nib[k] = b;
            tx_s = {tx_s[21:0], b};
        end
        if (inv) nib = ~nib;
        q = level(nib[1:0]);
        if (qflip) q = -q;
        drive(1, level(nib[3:2]), q, c, r);
    endtask

    always @(posedge clk) begin
        e_bits = n_bits; e_bv = n_bv; e_se = n_se; e_lk = n_lk; e_bc = n_bc; e_ec = n_ec;
    end

    // single compare process: every output, every cycle, on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("bits_out", 32'(bits_out), 32'(e_bits));
            check("bits_valid", 32'(bits_valid), 32'(e_bv));
            check("sym_err", 32'(sym_err), 32'(e_se));
            check("locked", 32'(locked), 32'(e_lk));
            check("bit_cnt", bit_cnt, e_bc);
            check("err_cnt", err_cnt, e_ec);
        end
    end

    initial begin
        logic [31:0] sl_exp [6];
        int          sl_in  [6];
        sl_in  = '{1296, 1295, 0, -1, -1295, -1296};
        sl_exp = '{32'hB, 32'hF, 32'hF, 32'h7, 32'h7, 32'h3};
        model(0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        drive(0, 0, 0, 0, 1);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_bit_cnt", bit_cnt, 32'd0);
        for (int k = 0; k < 6; k++) begin
            drive(1, sl_in[k], 0, 0, 0);
            check("slicer_boundary", 32'(bits_out), sl_exp[k]);
        end
        drive(0, 0, 0, 0, 1);
        for (int n = 1; n <= 40; n++) begin
            send_tx(0, 0, 0, 0);
            if (n == 13) check("lock_not_yet_13", 32'(locked), 32'd0);
            if (n == 14) check("lock_at_14", 32'(locked), 32'd1);
            if (n % 9 == 0) idle(2);
        end
        check("clean_bit_cnt", bit_cnt, 32'd104);
        check("clean_err_cnt", err_cnt, 32'd0);
        send_tx(0, 1, 0, 0);
        check("qflip_sym_err", 32'(sym_err), 32'd1);
        check("qflip_err_cnt", err_cnt, 32'd1);
        check("qflip_locked", 32'(locked), 32'd1);
        send_tx(0, 0, 1, 0);
        check("clr_bit_cnt", bit_cnt, 32'd0);
        check("clr_err_cnt", err_cnt, 32'd0);
        check("clr_locked", 32'(locked), 32'd1);
        check("clr_sym_err", 32'(sym_err), 32'd0);
        for (int n = 1; n <= 16; n++) begin
            send_tx(1, 0, 0, 0);
            if (n == 3) check("loss_not_yet", 32'(locked), 32'd1);
            if (n == 4) check("loss_at_4", 32'(locked), 32'd0);
        end
        for (int n = 0; n < 40; n++) send_tx(0, 0, 0, 0);
        check("reacquired", 32'(locked), 32'd1);
        force dut.bit_cnt = 32'hFFFF_FFF8;
        #1;
        release dut.bit_cnt;
        m_bit = 64'hFFFF_FFF8;
        n_bc = 32'hFFFF_FFF8;
        e_bc = 32'hFFFF_FFF8;
        send_tx(0, 0, 0, 0);
        check("sat_step", bit_cnt, 32'hFFFF_FFFC);
        send_tx(0, 0, 0, 0);
        check("sat_hit", bit_cnt, 32'hFFFF_FFFF);
        send_tx(0, 0, 0, 0);
        check("sat_hold", bit_cnt, 32'hFFFF_FFFF);
        send_tx(0, 0, 0, 1);
        check("rst_bits_out", 32'(bits_out), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_bit_cnt", bit_cnt, 32'd0);
        check("rst_err_cnt", err_cnt, 32'd0);
        check("rst_bits_valid", 32'(bits_valid), 32'd0);
        for (int n = 0; n < 16; n++) send_tx(0, 0, 0, 0);
        check("relock_after_rst", 32'(locked), 32'd1);
        idle(1);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
